// File: rtl/rx_fifo.sv
// rx_fifo: first-word-fall-through receive buffer behind the UART receiver,
// with a sticky overrun flag for bytes dropped while full. Rev 1.0
`default_nettype none

module rx_fifo #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rdy,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overrun_q, overrun_d;
  logic              push, pop, drop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign overrun = overrun_q;

  assign pop  = rd_en && !empty;
  assign push = rdy && (!full || pop);
  assign drop = rdy && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr_overrun) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left unreset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && res_n) mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_byte;
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed self-checking bench for rx_fifo.
`default_nettype none

module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] rx_byte;
  logic       rdy;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] level;
  logic       overrun;
  logic       clr_overrun;

  int errors = 0;
  int checks = 0;

  rx_fifo #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk         (clk),
    .res_n       (res_n),
    .rx_byte     (rx_byte),
    .rdy         (rdy),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    res_n = 1'b0; rx_byte = 8'h00; rdy = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;

    // Reset
    step(); step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    res_n = 1'b1;
    step(); step();
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);

    // Single byte
    rdy = 1'b1; rx_byte = 8'hA5; step(); rdy = 1'b0; rx_byte = 8'h00;
    check("single_empty", 32'(empty), 32'd0);
    check("single_level", 32'(level), 32'd1);
    check("single_data", 32'(rd_data), 32'hA5);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("single_pop_empty", 32'(empty), 32'd1);
    check("single_pop_level", 32'(level), 32'd0);

    // Fill and overrun
    for (int i = 0; i < 8; i++) begin
      rdy = 1'b1; rx_byte = 8'(i); step();
    end
    rdy = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd8);
    check("fill_overrun", 32'(overrun), 32'd0);
    rdy = 1'b1; rx_byte = 8'hFF; step(); rdy = 1'b0;
    check("drop_overrun", 32'(overrun), 32'd1);
    check("drop_level", 32'(level), 32'd8);
    check("drop_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 32'(rd_data), 32'(i));
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_level", 32'(level), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);

    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < 8; i++) begin
      rdy = 1'b1; rx_byte = 8'h10 + 8'(i); step();
    end
    rdy = 1'b1; rx_byte = 8'hEE; clr_overrun = 1'b1; step();
    rdy = 1'b0; clr_overrun = 1'b0;
    check("set_wins_overrun", 32'(overrun), 32'd1);
    check("set_wins_level", 32'(level), 32'd8);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("clr_again", 32'(overrun), 32'd0);

    // Full with simultaneous push and pop
    check("full_head", 32'(rd_data), 32'h10);
    rdy = 1'b1; rx_byte = 8'h55; rd_en = 1'b1; step();
    rdy = 1'b0; rd_en = 1'b0;
    check("pp_full_overrun", 32'(overrun), 32'd0);
    check("pp_full_level", 32'(level), 32'd8);
    check("pp_full_full", 32'(full), 32'd1);
    check("pp_full_head", 32'(rd_data), 32'h11);
    for (int i = 0; i < 7; i++) begin
      check("pp_drain_data", 32'(rd_data), 32'h11 + 32'(i));
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    check("pp_last_data", 32'(rd_data), 32'h55);
    check("pp_last_level", 32'(level), 32'd1);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("pp_drain_empty", 32'(empty), 32'd1);

    // rdy with rd_en while empty: push only
    rdy = 1'b1; rd_en = 1'b1; rx_byte = 8'hC3; step();
    rdy = 1'b0; rd_en = 1'b0;
    check("empty_pp_level", 32'(level), 32'd1);
    check("empty_pp_data", 32'(rd_data), 32'hC3);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("empty_pp_pop", 32'(empty), 32'd1);

    // Wrap-around with interleaved push/pop
    for (int i = 0; i < 20; i++) begin
      rdy = 1'b1; rx_byte = 8'h80 + 8'(i); step(); rdy = 1'b0;
      check("wrap_level", 32'(level), 32'd1);
      check("wrap_data", 32'(rd_data), 32'h80 + 32'(i));
      rd_en = 1'b1; step(); rd_en = 1'b0;
      check("wrap_empty", 32'(empty), 32'd1);
    end
    check("wrap_overrun", 32'(overrun), 32'd0);

    // Async reset mid-operation
    for (int i = 0; i < 5; i++) begin
      rdy = 1'b1; rx_byte = 8'h30 + 8'(i); step();
    end
    rdy = 1'b0;
    check("mid_level", 32'(level), 32'd5);
    #2 res_n = 1'b0;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_level", 32'(level), 32'd0);
    step(); res_n = 1'b1;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("empty_pop_level", 32'(level), 32'd0);
    check("empty_pop_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
